// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state and captured-op
// encodings, plus the default wait-state count.
package dm_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } dm_state_t;

    typedef enum logic {
        DM_OP_READ  = 1'b0,
        DM_OP_WRITE = 1'b1
    } dm_op_t;

    localparam int DM_WAIT_CYCLES_DEFAULT = 2;
    localparam int DM_CNT_W               = 4;

endpackage

// File: rtl/dm_responder_sram_array.sv
// Single-port synchronous word array with a registered read port; the read
// register holds its value until the next read or clear.
module dm_sram_array
    import dm_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic                  clear,
    input  logic [DEPTH_LOG2-1:0] word_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Array contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[word_addr] <= write_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_data <= '0;
        end else if (clear) begin
            read_data <= '0;
        end else if (read_en) begin
            read_data <= mem[word_addr];
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: captures a CPU read/write strobe, inserts WAIT_CYCLES
// wait states, accesses the array and pulses dm_ready. Optional address-fault
// checking is enabled by defining DM_ERR_CHECK_EN.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_LOG2  = 12,
    parameter int WAIT_CYCLES = DM_WAIT_CYCLES_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  do_dm_read,
    input  logic                  do_dm_write,
    input  logic [31:0]           dm_address,
    input  logic [DATA_WIDTH-1:0] dm_in,
    output logic [DATA_WIDTH-1:0] dm_out,
    output logic                  dm_busy,
    output logic                  dm_ready,
    output logic                  dm_error
);

    localparam logic [DM_CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? DM_CNT_W'(WAIT_CYCLES - 1) : '0;

    dm_state_t             state, state_next;
    logic [DM_CNT_W-1:0]   cnt, cnt_next;
    dm_op_t                op_q;
    logic [DEPTH_LOG2-1:0] word_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  capture;
    logic                  fault_q;

    assign capture = (state == ST_IDLE) && (do_dm_read || do_dm_write);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= DM_OP_READ;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (capture) begin
                // A simultaneous read+write is serviced as the write alone.
                op_q <= do_dm_write ? DM_OP_WRITE : DM_OP_READ;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (capture) begin
            word_q <= dm_address[DEPTH_LOG2+1:2];
            din_q  <= dm_in;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (capture) begin
                    cnt_next   = CNT_LOAD;
                    state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_next = ST_ACCESS;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

`ifdef DM_ERR_CHECK_EN
    function automatic logic addr_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:DEPTH_LOG2+2] != '0);
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (capture) begin
            fault_q <= addr_fault(dm_address);
        end
    end

    assign dm_error = (state == ST_RESP) && fault_q;
`else
    // Byte-offset and upper address bits are ignored; upper bits alias.
    logic addr_unused;
    assign addr_unused = ^{dm_address[1:0], dm_address[31:DEPTH_LOG2+2]};
    assign fault_q     = 1'b0;
    assign dm_error    = 1'b0;
`endif

    logic access_rd, access_wr;
    assign access_rd = (state == ST_ACCESS) && (op_q == DM_OP_READ);
    assign access_wr = (state == ST_ACCESS) && (op_q == DM_OP_WRITE);

    dm_sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clock      (clock),
        .reset      (reset),
        .write_en   (access_wr && !fault_q),
        .read_en    (access_rd && !fault_q),
        .clear      (access_rd && fault_q),
        .word_addr  (word_q),
        .write_data (din_q),
        .read_data  (dm_out)
    );

    assign dm_busy  = (state != ST_IDLE);
    assign dm_ready = (state == ST_RESP);

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance driven by
// a vector table, hand-written reset/hold sequences and a random model check.
module tb_dm_responder;

    logic        clock;
    logic        reset;
    logic        rd2, wr2, rd0, wr0;
    logic [31:0] addr2, addr0, din2, din0;
    logic [31:0] out2, out0;
    logic        busy2, busy0, ready2, ready0, err2, err0;

    int nvec  = 0;
    int nfail = 0;

    dm_responder #(.DATA_WIDTH(32), .DEPTH_LOG2(12), .WAIT_CYCLES(2)) u_dut2 (
        .clock(clock), .reset(reset), .do_dm_read(rd2), .do_dm_write(wr2),
        .dm_address(addr2), .dm_in(din2), .dm_out(out2), .dm_busy(busy2),
        .dm_ready(ready2), .dm_error(err2)
    );

    dm_responder #(.DATA_WIDTH(32), .DEPTH_LOG2(12), .WAIT_CYCLES(0)) u_dut0 (
        .clock(clock), .reset(reset), .do_dm_read(rd0), .do_dm_write(wr0),
        .dm_address(addr0), .dm_in(din0), .dm_out(out0), .dm_busy(busy0),
        .dm_ready(ready0), .dm_error(err0)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: word-indexed memories and the last read result per instance.
    logic [31:0] mem_m2 [int];
    logic [31:0] mem_m0 [int];
    logic [31:0] last2 = '0;
    logic [31:0] last0 = '0;

    function automatic bit is_fault(input logic [31:0] a);
`ifdef DM_ERR_CHECK_EN
        return ((a % 4) != 0) || ((a >> 14) != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_apply(input int which, input bit rd, input bit wr,
                               input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] exp_out, output bit exp_err);
        int  idx;
        bit  f;
        idx = int'((a >> 2) % 4096);
        f   = is_fault(a);
        if (wr) begin
            if (!f) begin
                if (which == 0) mem_m0[idx] = d;
                else            mem_m2[idx] = d;
            end
        end else if (rd) begin
            if (which == 0) last0 = f ? 32'h0 : mem_m0[idx];
            else            last2 = f ? 32'h0 : mem_m2[idx];
        end
        exp_out = (which == 0) ? last0 : last2;
        exp_err = f;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input int which, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (which == 0) begin
            rd0 = rd; wr0 = wr; addr0 = a; din0 = d;
        end else begin
            rd2 = rd; wr2 = wr; addr2 = a; din2 = d;
        end
    endtask

    // One complete transaction; latency counts edges from capture to the edge
    // that samples dm_ready high.
    task automatic txn(input string name, input int which, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_out, input bit exp_err);
        int n;
        int busy_n;
        bit done;
        n = 0; busy_n = 0; done = 1'b0;
        @(negedge clock);
        drive(which, rd, wr, a, d);
        @(posedge clock);
        while (!done && n < 40) begin
            @(negedge clock);
            if (n == 0) drive(which, 1'b0, 1'b0, a, d);
            n++;
            if ((which == 0) ? busy0 : busy2) busy_n++;
            if ((which == 0) ? ready0 : ready2) done = 1'b1;
        end
        if (!done) begin
            nvec++;
            nfail++;
            $display("FAIL %s timeout: no dm_ready within %0d cycles", name, n);
        end else begin
            check({name, " latency"}, 32'(n), 32'(which + 2));
            check({name, " busy_cycles"}, 32'(busy_n), 32'(which + 2));
            check({name, " dm_out"}, (which == 0) ? out0 : out2, exp_out);
            check({name, " dm_error"}, 32'((which == 0) ? err0 : err2), 32'(exp_err));
        end
    endtask

    typedef struct {
        int          which;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_out;
        bit          exp_err;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic [31:0] eo;
        bit          ee;
        int          rdy_n;
        int          idle_n;

        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);

        tbl[0]  = '{2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0};
        tbl[1]  = '{2, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{2, 1'b0, 1'b1, 32'h24, 32'h11, 32'hDEADBEEF, 1'b0};
        tbl[3]  = '{2, 1'b1, 1'b0, 32'h24, 32'h0, 32'h11, 1'b0};
        tbl[4]  = '{2, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 32'h11, 1'b0};
        tbl[5]  = '{2, 1'b1, 1'b0, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0};
        tbl[6]  = '{2, 1'b0, 1'b1, 32'h40, 32'h5A, 32'hA5A5A5A5, 1'b0};
        tbl[7]  = '{0, 1'b0, 1'b1, 32'h0, 32'h12345678, 32'h0, 1'b0};
        tbl[8]  = '{0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0};
        tbl[9]  = '{2, 1'b0, 1'b1, 32'h0, 32'h1, 32'hA5A5A5A5, 1'b0};
`ifdef DM_ERR_CHECK_EN
        tbl[10] = '{2, 1'b0, 1'b1, 32'h4000, 32'h77, 32'hA5A5A5A5, 1'b1};
        tbl[11] = '{2, 1'b1, 1'b0, 32'h0, 32'h0, 32'h1, 1'b0};
        tbl[12] = '{2, 1'b0, 1'b1, 32'h2, 32'h99, 32'h1, 1'b1};
        tbl[13] = '{2, 1'b1, 1'b0, 32'h0, 32'h0, 32'h1, 1'b0};
        tbl[14] = '{2, 1'b1, 1'b0, 32'h4000, 32'h0, 32'h0, 1'b1};
`else
        tbl[10] = '{2, 1'b0, 1'b1, 32'h4000, 32'h77, 32'hA5A5A5A5, 1'b0};
        tbl[11] = '{2, 1'b1, 1'b0, 32'h0, 32'h0, 32'h77, 1'b0};
        tbl[12] = '{2, 1'b0, 1'b1, 32'h6, 32'h99, 32'h77, 1'b0};
        tbl[13] = '{2, 1'b1, 1'b0, 32'h4, 32'h0, 32'h99, 1'b0};
        tbl[14] = '{2, 1'b1, 1'b0, 32'h8004, 32'h0, 32'h99, 1'b0};
`endif

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset busy", 32'({busy2, busy0}), 32'h0);
        check("reset ready", 32'({ready2, ready0}), 32'h0);
        check("reset error", 32'({err2, err0}), 32'h0);
        check("reset dm_out2", out2, 32'h0);
        check("reset dm_out0", out0, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        check("idle busy", 32'({busy2, busy0}), 32'h0);

        for (int i = 0; i < 15; i++) begin
            model_apply(tbl[i].which, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, eo, ee);
            txn($sformatf("tbl%0d", i), tbl[i].which, tbl[i].rd, tbl[i].wr,
                tbl[i].addr, tbl[i].data, tbl[i].exp_out, tbl[i].exp_err);
        end

        // Reset during the wait states of a write: the write must be dropped.
        @(negedge clock);
        drive(2, 1'b0, 1'b1, 32'h40, 32'hFFFFFFFF);
        @(posedge clock);
        @(negedge clock);
        drive(2, 1'b0, 1'b0, 32'h40, 32'h0);
        check("midrst busy_before", 32'(busy2), 32'h1);
        reset = 1'b1;
        #1;
        check("midrst busy", 32'(busy2), 32'h0);
        check("midrst ready", 32'(ready2), 32'h0);
        check("midrst error", 32'(err2), 32'h0);
        check("midrst dm_out", out2, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        last2 = '0;
        last0 = '0;
        model_apply(2, 1'b1, 1'b0, 32'h40, 32'h0, eo, ee);
        txn("midrst read", 2, 1'b1, 1'b0, 32'h40, 32'h0, 32'h5A, 1'b0);

        // Read strobe held high: one access per dm_ready, restarting from IDLE.
        rdy_n = 0;
        idle_n = 0;
        @(negedge clock);
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (ready0) rdy_n++;
            if (!busy0) idle_n++;
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 4; k++) model_apply(0, 1'b1, 1'b0, 32'h0, 32'h0, eo, ee);
        check("hold ready_pulses", 32'(rdy_n), 32'd4);
        check("hold idle_cycles", 32'(idle_n), 32'd4);
        check("hold dm_out", out0, 32'h12345678);

        // Random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            int          which;
            int          idx;
            bit          rd;
            bit          wr;
            logic [31:0] a;
            logic [31:0] d;
            which = ($urandom_range(0, 1) == 0) ? 0 : 2;
            idx   = int'($urandom_range(0, 4095));
            a     = 32'(idx) * 4;
            if ($urandom_range(0, 3) == 0) a = a + ($urandom << 14);
            if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
            d  = $urandom;
            rd = ($urandom_range(0, 1) == 1);
            idx = int'((a >> 2) % 4096);
            if (rd && !is_fault(a) &&
                !((which == 0) ? mem_m0.exists(idx) : mem_m2.exists(idx))) rd = 1'b0;
            wr = !rd || ($urandom_range(0, 4) == 0);
            model_apply(which, rd, wr, a, d, eo, ee);
            txn($sformatf("rnd%0d", i), which, rd, wr, a, d, eo, ee);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
